gray_counter: RTL and testbench
===============================

// Module: gray_counter
// PURPOSE
//   Registered up/down Gray-code counter that generates the Gray word consumed
//   by the downstream gray-to-binary converter.
//   Keeps an internal binary count and registers its Gray encoding, so exactly
//   one output bit changes per step and the outputs are glitch-free.
//   Supports enable, direction, parallel binary load, and wrap or saturate at
//   the range ends.
// PARAMETERS
//   WIDTH     4  counter / Gray word width in bits (>=2)
//   SATURATE  0  0: wrap at ends; 1: hold at ends (no wrap)
// PORTS
//   clk       in   1      rising-edge clock, single domain
//   rst       in   1      synchronous reset, active-high
//   en        in   1      count enable; one step per cycle while high
//   up_dn     in   1      1 = count up, 0 = count down (sampled with en)
//   load      in   1      parallel load strobe
//   load_bin  in   WIDTH  binary value to load
//   g         out  WIDTH  registered Gray code = bcnt ^ (bcnt >> 1)
//   b_mon     out  WIDTH  registered binary count (bcnt), for checking only
//   wrap      out  1      1-cycle pulse; g took a wrapped value this cycle
//   at_end    out  1      level; bcnt == all-ones (up_dn=1) or 0 (up_dn=0)
//   chg       out  1      1-cycle pulse; g differs from its previous value
// BEHAVIOUR
//   - Reset (rst=1 at a clk edge): bcnt=0, g=0, wrap=0, chg=0.
//     Overrides load and en; a mid-count reset takes effect at that edge.
//   - Priority per edge: rst > load > en > hold.
//   - load=1: bcnt <= load_bin, g <= gray(load_bin), wrap <= 0.
//     chg=1 only if the new g differs from the old g.
//   - en=1, load=0, up_dn=1: bcnt <= bcnt+1 (modulo 2^WIDTH).
//   - en=1, load=0, up_dn=0: bcnt <= bcnt-1 (modulo 2^WIDTH).
//   - Wrap case (SATURATE=0):
//     up from 2^WIDTH-1 to 0, or down from 0 to 2^WIDTH-1.
//     wrap=1 in the same cycle g shows the wrapped value.
//   - SATURATE=1 at the end in the current direction:
//     bcnt holds, wrap stays 0, chg=0.
//   - en=0, load=0: all state holds; wrap=0, chg=0.
//   - Latency: g, b_mon, wrap and chg update 1 cycle after the sampling edge.
//     at_end is combinational from bcnt and up_dn.
//   - Invariants on every count step:
//     g == gray(b_mon); Hamming(g_prev, g) == 1.
//     Loads are exempt from the one-bit-change rule.
//   - Width rules:
//     Arithmetic is unsigned WIDTH bits; the carry out is discarded.
//     Gray mapping: g[WIDTH-1] = b[WIDTH-1], g[i] = b[i+1] ^ b[i].
// TESTING (WIDTH=4)
//   1 Reset then en=1, up_dn=1 for 16 cycles. Required g sequence:
//     0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,
//     1001,1000, then 0000 with wrap=1 for exactly 1 cycle.
//   2 From reset, en=1, up_dn=0 -> g=1000, b_mon=1111, wrap=1.
//     Next cycle: g=1001, wrap=0.
//   3 load=1, load_bin=0101 together with en=1 -> load wins.
//     g=0111, b_mon=0101; next up step gives g=0101.
//   4 SATURATE=1, load 1111, en=1, up_dn=1 for 3 cycles.
//     g stays 1000, wrap=0, chg=0, at_end=1.
//     Then up_dn=0 -> g=1001.
//   5 Count up to b_mon=0110, then assert rst for 1 cycle with en=1 and load=1.
//     Next cycle: g=0000, wrap=0.
//   6 Random en/up_dn/load stimulus for 1000 cycles:
//     scoreboard checks g==gray(b_mon), a one-bit change per count step,
//     and that chg/wrap match the model.

Source files
------------

// File: rtl/gray_counter.sv
// Up/down Gray-code counter with parallel load and wrap or saturate at the range ends.
// Latency: g, b_mon, wrap and chg are registered one cycle after the sampling edge; at_end is combinational.
// Backpressure: none; the counter takes one action on every clock edge.
module gray_counter #(
    parameter int WIDTH    = 4,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] b_mon,
    output logic             wrap,
    output logic             at_end,
    output logic             chg
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [WIDTH-1:0] bcnt;
    logic [WIDTH-1:0] bcnt_nxt;
    logic [WIDTH-1:0] load_gray;

    assign b_mon     = bcnt;
    assign at_end    = up_dn ? (&bcnt) : ~(|bcnt);
    assign bcnt_nxt  = up_dn ? (bcnt + ONE) : (bcnt - ONE);
    assign load_gray = to_gray(load_bin);

    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt <= '0;
            g    <= '0;
            wrap <= 1'b0;
            chg  <= 1'b0;
        end else if (load) begin
            bcnt <= load_bin;
            g    <= load_gray;
            wrap <= 1'b0;
            chg  <= (load_gray != g);
        end else if (en) begin
            // In saturate mode the end of range blocks the step in that direction only.
            if ((SATURATE != 0) && at_end) begin
                wrap <= 1'b0;
                chg  <= 1'b0;
            end else begin
                bcnt <= bcnt_nxt;
                g    <= to_gray(bcnt_nxt);
                wrap <= at_end;
                chg  <= 1'b1;
            end
        end else begin
            wrap <= 1'b0;
            chg  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gray_counter.sv
// Drives a wrapping and a saturating gray_counter with shared stimulus and checks both against a counting model.
module tb_gray_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up_dn = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_bin = 4'd0;

    logic [3:0] g_o [2];
    logic [3:0] b_o [2];
    logic       wrap_o [2];
    logic       at_end_o [2];
    logic       chg_o [2];

    int n_vec = 0;
    int n_err = 0;

    // model state: index 0 = wrapping instance, 1 = saturating instance
    int m_cnt [2];
    int m_wrap [2];
    int m_chg [2];
    int m_counted [2];
    logic [3:0] g_prev [2];

    always #5 clk = ~clk;

    gray_counter #(.WIDTH(4), .SATURATE(0)) dut (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_bin(load_bin),
        .g(g_o[0]), .b_mon(b_o[0]), .wrap(wrap_o[0]), .at_end(at_end_o[0]), .chg(chg_o[0])
    );

    gray_counter #(.WIDTH(4), .SATURATE(1)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_bin(load_bin),
        .g(g_o[1]), .b_mon(b_o[1]), .wrap(wrap_o[1]), .at_end(at_end_o[1]), .chg(chg_o[1])
    );

    function automatic logic [3:0] gray_of(input int v);
        logic [3:0] b;
        b = 4'(v);
        return b ^ (b >> 1);
    endfunction

    function automatic int model_at_end(input int idx);
        return up_dn ? int'(m_cnt[idx] == 15) : int'(m_cnt[idx] == 0);
    endfunction

    // Apply one cycle of stimulus, advance the model, and leave time 1 unit past the edge.
    task automatic step(input logic r, input logic e, input logic u, input logic l, input logic [3:0] lb);
        rst = r; en = e; up_dn = u; load = l; load_bin = lb;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            g_prev[i] = gray_of(m_cnt[i]);
            m_counted[i] = 0;
            if (r) begin
                m_cnt[i] = 0; m_wrap[i] = 0; m_chg[i] = 0;
            end else if (l) begin
                m_chg[i] = int'(gray_of(int'(lb)) != gray_of(m_cnt[i]));
                m_cnt[i] = int'(lb); m_wrap[i] = 0;
            end else if (e) begin
                if ((u && m_cnt[i] == 15) || (!u && m_cnt[i] == 0)) begin
                    if (i == 1) begin
                        m_wrap[i] = 0; m_chg[i] = 0;
                    end else begin
                        m_cnt[i] = u ? 0 : 15; m_wrap[i] = 1; m_chg[i] = 1; m_counted[i] = 1;
                    end
                end else begin
                    m_cnt[i] = u ? m_cnt[i] + 1 : m_cnt[i] - 1;
                    m_wrap[i] = 0; m_chg[i] = 1; m_counted[i] = 1;
                end
            end else begin
                m_wrap[i] = 0; m_chg[i] = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset;
        step(1, 0, 0, 0, 4'd0);
        step(1, 1, 1, 1, 4'd9);
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if ({g_o[i], b_o[i], wrap_o[i], chg_o[i]} !== 10'd0) begin
                n_err++;
                $display("FAIL reset[%0d]: g=%b b=%b wrap=%b chg=%b, required all zero",
                         i, g_o[i], b_o[i], wrap_o[i], chg_o[i]);
            end
        end
    endtask

    task automatic test_up_wrap;
        logic [3:0] seq [17];
        seq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
        step(1, 0, 1, 0, 4'd0);
        n_vec++;
        if (g_o[0] !== seq[0]) begin
            n_err++; $display("FAIL up_seq[0]: g=%b required %b", g_o[0], seq[0]);
        end
        for (int k = 1; k <= 16; k++) begin
            step(0, 1, 1, 0, 4'd0);
            n_vec++;
            if (g_o[0] !== seq[k] || wrap_o[0] !== (k == 16)) begin
                n_err++;
                $display("FAIL up_seq[%0d]: g=%b wrap=%b required g=%b wrap=%b",
                         k, g_o[0], wrap_o[0], seq[k], (k == 16));
            end
        end
        step(0, 0, 1, 0, 4'd0);
        n_vec++;
        if (wrap_o[0] !== 1'b0 || g_o[0] !== 4'b0000) begin
            n_err++; $display("FAIL up_wrap_pulse: g=%b wrap=%b required g=0000 wrap=0", g_o[0], wrap_o[0]);
        end
    endtask

    task automatic test_down_wrap;
        step(1, 0, 0, 0, 4'd0);
        step(0, 1, 0, 0, 4'd0);
        n_vec++;
        if (g_o[0] !== 4'b1000 || b_o[0] !== 4'b1111 || wrap_o[0] !== 1'b1) begin
            n_err++;
            $display("FAIL down_wrap: g=%b b=%b wrap=%b required g=1000 b=1111 wrap=1", g_o[0], b_o[0], wrap_o[0]);
        end
        n_vec++;
        if (g_o[1] !== 4'b0000 || wrap_o[1] !== 1'b0 || chg_o[1] !== 1'b0 || at_end_o[1] !== 1'b1) begin
            n_err++;
            $display("FAIL down_sat_floor: g=%b wrap=%b chg=%b at_end=%b required 0000/0/0/1",
                     g_o[1], wrap_o[1], chg_o[1], at_end_o[1]);
        end
        step(0, 1, 0, 0, 4'd0);
        n_vec++;
        if (g_o[0] !== 4'b1001 || wrap_o[0] !== 1'b0) begin
            n_err++; $display("FAIL down_next: g=%b wrap=%b required g=1001 wrap=0", g_o[0], wrap_o[0]);
        end
    endtask

    task automatic test_load_priority;
        step(1, 0, 1, 0, 4'd0);
        step(0, 1, 1, 1, 4'b0101);
        n_vec++;
        if (g_o[0] !== 4'b0111 || b_o[0] !== 4'b0101 || chg_o[0] !== 1'b1 || wrap_o[0] !== 1'b0) begin
            n_err++;
            $display("FAIL load_wins: g=%b b=%b chg=%b wrap=%b required g=0111 b=0101 chg=1 wrap=0",
                     g_o[0], b_o[0], chg_o[0], wrap_o[0]);
        end
        step(0, 1, 1, 0, 4'd0);
        n_vec++;
        if (g_o[0] !== 4'b0101) begin
            n_err++; $display("FAIL load_then_up: g=%b required 0101", g_o[0]);
        end
        step(0, 0, 1, 1, 4'b0110);
        n_vec++;
        if (chg_o[0] !== 1'b0 || g_o[0] !== 4'b0101) begin
            n_err++; $display("FAIL load_same_value: g=%b chg=%b required g=0101 chg=0", g_o[0], chg_o[0]);
        end
    endtask

    task automatic test_saturate;
        step(0, 0, 1, 1, 4'b1111);
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 1, 0, 4'd0);
            n_vec++;
            if (g_o[1] !== 4'b1000 || wrap_o[1] !== 1'b0 || chg_o[1] !== 1'b0 || at_end_o[1] !== 1'b1) begin
                n_err++;
                $display("FAIL sat_hold[%0d]: g=%b wrap=%b chg=%b at_end=%b required 1000/0/0/1",
                         k, g_o[1], wrap_o[1], chg_o[1], at_end_o[1]);
            end
        end
        step(0, 1, 0, 0, 4'd0);
        n_vec++;
        if (g_o[1] !== 4'b1001 || chg_o[1] !== 1'b1 || at_end_o[1] !== 1'b0) begin
            n_err++;
            $display("FAIL sat_reverse: g=%b chg=%b at_end=%b required g=1001 chg=1 at_end=0",
                     g_o[1], chg_o[1], at_end_o[1]);
        end
    endtask

    task automatic test_mid_reset;
        step(1, 0, 1, 0, 4'd0);
        for (int k = 0; k < 6; k++) step(0, 1, 1, 0, 4'd0);
        n_vec++;
        if (b_o[0] !== 4'b0110) begin
            n_err++; $display("FAIL mid_count: b=%b required 0110", b_o[0]);
        end
        step(1, 1, 1, 1, 4'b1010);
        n_vec++;
        if (g_o[0] !== 4'b0000 || wrap_o[0] !== 1'b0 || b_o[0] !== 4'b0000) begin
            n_err++;
            $display("FAIL mid_reset: g=%b b=%b wrap=%b required g=0000 b=0000 wrap=0", g_o[0], b_o[0], wrap_o[0]);
        end
    endtask

    task automatic test_random;
        logic r, e, u, l;
        logic [3:0] lb;
        for (int c = 0; c < 1000; c++) begin
            r  = ($urandom_range(0, 49) == 0);
            l  = ($urandom_range(0, 7) == 0);
            e  = ($urandom_range(0, 3) != 0);
            u  = ($urandom_range(0, 2) != 0);
            lb = 4'($urandom_range(0, 15));
            step(r, e, u, l, lb);
            for (int i = 0; i < 2; i++) begin
                n_vec++;
                if (g_o[i] !== gray_of(m_cnt[i]) || b_o[i] !== 4'(m_cnt[i]) ||
                    wrap_o[i] !== 1'(m_wrap[i]) || chg_o[i] !== 1'(m_chg[i]) ||
                    at_end_o[i] !== 1'(model_at_end(i))) begin
                    n_err++;
                    $display("FAIL random[%0d] inst%0d: g=%b b=%b wrap=%b chg=%b at_end=%b required g=%b b=%b wrap=%0d chg=%0d at_end=%0d",
                             c, i, g_o[i], b_o[i], wrap_o[i], chg_o[i], at_end_o[i],
                             gray_of(m_cnt[i]), 4'(m_cnt[i]), m_wrap[i], m_chg[i], model_at_end(i));
                end
                n_vec++;
                if (g_o[i] !== (b_o[i] ^ (b_o[i] >> 1))) begin
                    n_err++; $display("FAIL random_gray_inv[%0d] inst%0d: g=%b b=%b", c, i, g_o[i], b_o[i]);
                end
                if (m_counted[i] != 0) begin
                    n_vec++;
                    if ($countones(g_o[i] ^ g_prev[i]) != 1) begin
                        n_err++;
                        $display("FAIL random_one_bit[%0d] inst%0d: prev g=%b g=%b, required one bit change",
                                 c, i, g_prev[i], g_o[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_wrap[i] = 0; m_chg[i] = 0; m_counted[i] = 0; g_prev[i] = 4'd0;
        end
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_load_priority();
        test_saturate();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
